sipo_deserializer: RTL
======================

# sipo_deserializer

Parametrised serial-in/parallel-out deserializer: the next generation of the team's 4-bit SIPO shift register. It assembles WIDTH-bit words from a gated serial bit stream, with selectable bit order, frame resynchronisation and a ready/valid output holding register. It sits between a serial receive front-end and word-oriented downstream logic. It also flags words lost to downstream back-pressure.

## Interface
- WIDTH, 8, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1: first received bit lands in out[WIDTH-1]; 0: first received bit lands in out[0].
- clock  in  1  single clock; all state changes on its rising edge.
- clear  in  1  reset, asynchronous, active-high.
- data_in  in  1  serial data bit; sampled only when data_valid=1.
- data_valid  in  1  bit strobe; one bit is accepted per clock with data_valid=1.
- frame_start  in  1  synchronous word-boundary marker; discards any partial word.
- out  out  WIDTH  completed word from the holding register.
- out_valid  out  1  holding register contains an unconsumed word.
- out_ready  in  1  downstream accepts; a transfer occurs on an edge where out_valid and out_ready are both 1.
- busy  out  1  partial word in progress (bit count non-zero).
- overrun  out  1  sticky; a completed word was dropped.
- overrun_clr  in  1  synchronous clear of overrun.

## Operation
- Internal state: shift register sh[WIDTH-1:0], bit counter cnt (0..WIDTH-1), holding register, out_valid flag, overrun flag.
- FSM has two states, derived from cnt:
  - IDLE (cnt=0).
  - SHIFT (0<cnt<WIDTH).
  - IDLE→SHIFT on an accepted bit.
  - SHIFT→IDLE on the WIDTH-th accepted bit, or on frame_start without data_valid.
- Accepted bit:
  - MSB_FIRST=1: sh <= {sh[WIDTH-2:0], data_in}.
  - MSB_FIRST=0: sh <= {data_in, sh[WIDTH-1:1]}.
  - cnt increments.
- Completion: the bit accepted at cnt=WIDTH-1 completes a word. The word is the shifted value including that bit. cnt wraps to 0.
- Completion with the holding register free (out_valid=0, or a transfer on the same edge):
  - out <= word; out_valid <= 1.
- Completion with the holding register occupied and no transfer on that edge:
  - word is dropped; out keeps its old value; overrun <= 1.
- Transfer without a completion on the same edge: out_valid <= 0; out holds its last value.
- frame_start=1, data_valid=0: cnt <= 0; sh is not cleared (don't-care); holding register unaffected.
- frame_start=1, data_valid=1: data_in is the first bit of a new word and cnt <= 1. For WIDTH bits this is never a completion.
- overrun:
  - cleared by overrun_clr.
  - If overrun_clr and a new drop occur on the same edge, set wins.
- busy = (cnt != 0); combinational from the register.
- Reset values: out=0, out_valid=0, overrun=0, busy=0, cnt=0, sh=0.

## Timing
- Word latency: out and out_valid update on the same edge that samples the WIDTH-th bit. Both are visible in the following cycle.
- Back-to-back words at full rate (data_valid continuously 1) are sustainable only if out_ready is 1 on every completion edge.
- out_ready has no effect while out_valid=0.
- All outputs are registered except busy, which is decoded from registered cnt. No combinational path exists from any input to any output.
- clear asserted mid-word:
  - all state returns to reset values immediately, without waiting for a clock edge.
  - the partial word and any pending output word are lost.
- First accepted bit after clear deasserts is bit 0 of a new word.

## Test plan
- WIDTH=8, MSB_FIRST=1: bits 1,1,0,0,0,0,0,0 with data_valid=1 and out_ready=0 → after the 8th edge out=8'hC0, out_valid=1, busy=0.
- Same bits with MSB_FIRST=0 → out=8'h03. Then pulse out_ready for one cycle → out_valid=0 and out stays 8'h03.
- Gapped stream: data_valid alternating 0/1 around the 8 bits of 8'hA5, MSB_FIRST=1 → out=8'hA5 after the 8th accepted bit; busy=1 throughout the gaps.
- Overrun:
  - send 8'h11 and leave it unread; send 8'h22 → out stays 8'h11 and overrun=1.
  - assert overrun_clr → overrun=0.
  - send 8'h33 with out_ready=1 on its completion edge → out=8'h33, out_valid=1, no overrun.
- Resync: send 3 bits, then frame_start=1 with data_valid=1 and data_in=1, then 7 bits 0 (MSB_FIRST=1) → out=8'h80, and no completion occurs after the first 3 bits.
- Async clear: assert clear between edges after 5 bits, with a valid word pending → out=0, out_valid=0, busy=0 before the next edge. The following 8 bits form a correct word.

Source files
------------

// File: rtl/sipo_deserializer.sv
// ---------------------------------------------------------------------------
// sipo_deserializer
//
// Assembles WIDTH-bit words from a gated serial bit stream and presents them
// through a ready/valid holding register. A word completed while the holding
// register still holds an unconsumed word is dropped and flagged in a sticky
// overrun bit. frame_start resynchronises the word boundary.
//
// Parameters
//   WIDTH      word length in bits (2..32)
//   MSB_FIRST  1: first received bit lands in out[WIDTH-1]
//              0: first received bit lands in out[0]
//
// Ports
//   clock        in   rising-edge clock
//   clear        in   asynchronous active-high reset
//   data_in      in   serial data bit, sampled when data_valid=1
//   data_valid   in   bit strobe, one bit accepted per clock
//   frame_start  in   word-boundary marker, discards any partial word
//   out          out  completed word (holding register)
//   out_valid    out  holding register contains an unconsumed word
//   out_ready    in   downstream accepts the word when out_valid=1
//   busy         out  partial word in progress
//   overrun      out  sticky: a completed word was dropped
//   overrun_clr  in   synchronous clear of overrun
// ---------------------------------------------------------------------------
module sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             data_in,
    input  logic             data_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             overrun_clr
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,   // cnt == 0
        SHIFT = 1'b1    // 0 < cnt < WIDTH
    } state_t;

    state_t            state, state_next;
    logic [CW-1:0]     cnt, cnt_next;
    logic [WIDTH-1:0]  sh, sh_next;
    logic [WIDTH-1:0]  out_next;
    logic              out_valid_next;
    logic              overrun_next;

    logic [WIDTH-1:0]  word;      // sh with the current data_in shifted in
    logic              complete;  // this edge accepts the WIDTH-th bit
    logic              transfer;  // downstream takes the held word this edge
    logic              drop;      // completed word has nowhere to go
    logic              load;      // completed word enters the holding register

    // Shift direction fixes where the first bit of a word ends up.
    always_comb begin
        if (MSB_FIRST) word = {sh[WIDTH-2:0], data_in};
        else           word = {data_in, sh[WIDTH-1:1]};
    end

    assign transfer = out_valid & out_ready;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the shift register is small enough to reset
    // along with everything else, so no power-up garbage ever reaches out.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state     <= IDLE;
            cnt       <= '0;
            sh        <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            sh        <= sh_next;
            out       <= out_next;
            out_valid <= out_valid_next;
            overrun   <= overrun_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sh_next    = sh;
        complete   = 1'b0;

        case (state)
            IDLE: begin
                // With cnt already 0, frame_start changes nothing here.
                if (data_valid) begin
                    sh_next    = word;
                    cnt_next   = CW'(1);
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (data_valid) begin
                    sh_next = word;
                    if (frame_start) begin
                        // Resync: this bit starts a fresh word. Stale bits in
                        // sh are shifted out before the word can complete.
                        cnt_next = CW'(1);
                    end else if (cnt == LAST) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                        complete   = 1'b1;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end else if (frame_start) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // Holding register and overrun flag. A transfer on the completion edge
    // frees the slot in time for the new word.
    always_comb begin
        drop           = complete & out_valid & ~transfer;
        load           = complete & ~drop;
        out_next       = out;
        out_valid_next = out_valid;
        overrun_next   = overrun;

        if (load) begin
            out_next       = word;
            out_valid_next = 1'b1;
        end else if (transfer) begin
            out_valid_next = 1'b0;
        end

        // A new drop outranks a simultaneous clear request.
        if (drop)             overrun_next = 1'b1;
        else if (overrun_clr) overrun_next = 1'b0;
    end

    // -----------------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------------
    always_comb begin
        busy = (cnt != '0);
    end

endmodule
